// File: rtl/wavefront_scheduler_pkg.sv
// Shared types and default sizing for the wavefront scheduler.
package wavefront_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } sched_state_t;

    localparam int unsigned NUM_PU_DEFAULT          = 4;
    localparam int unsigned CYCLES_PER_DIAG_DEFAULT = 4;
    localparam int unsigned DRAIN_CYCLES_DEFAULT    = 2;

    localparam int unsigned NUM_DIAGONALS   = 2 * NUM_PU_DEFAULT - 1;
    localparam int unsigned NUM_DIAGONALS_W = $clog2(NUM_DIAGONALS);

endpackage

// File: rtl/wavefront_scheduler_pu_mask_gen.sv
// Combinational diagonal -> PU write mask. PU i owns tile (row i, col diag-i),
// so it is active when that column lies inside the grid.
module pu_mask_gen #(
    parameter int unsigned NUM_PU = 4,
    parameter int unsigned DIAG_W = 3
) (
    input  logic [DIAG_W-1:0] diag,
    output logic [NUM_PU-1:0] mask
);

    // Bit i set iff 0 <= diag-i <= NUM_PU-1.
    always_comb begin
        mask = '0;
        for (int i = 0; i < int'(NUM_PU); i++) begin
            mask[i] = (i <= int'(diag)) && (int'(diag) <= i + int'(NUM_PU) - 1);
        end
    end

endmodule

// File: rtl/wavefront_scheduler.sv
// Steps the PU array through the anti-diagonal wavefronts of an NUM_PU x NUM_PU
// tile grid, pulsing the write strobes once per diagonal, then drains.
module wavefront_scheduler
    import wavefront_scheduler_pkg::*;
#(
    parameter int unsigned NUM_PU          = NUM_PU_DEFAULT,
    parameter int unsigned CYCLES_PER_DIAG = CYCLES_PER_DIAG_DEFAULT,
    parameter int unsigned DRAIN_CYCLES    = DRAIN_CYCLES_DEFAULT,
    localparam int unsigned N_DIAG         = 2 * NUM_PU - 1,
    // Clamped to 1 so a single-PU build keeps a legal port width.
    localparam int unsigned DIAG_W         = (N_DIAG > 1) ? $clog2(N_DIAG) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    output logic              ready,
    output logic              busy,
    output logic [NUM_PU-1:0] wr_en_pu,
    output logic [N_DIAG-1:0] write_ctl,
    output logic [DIAG_W-1:0] choose_diagonal,
    output logic              wr_en_max,
    output logic              done
);

    localparam int unsigned CYC_W = (CYCLES_PER_DIAG > 1) ? $clog2(CYCLES_PER_DIAG) : 1;
    localparam int unsigned DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(CYCLES_PER_DIAG - 1);
    localparam logic [DIAG_W-1:0] DIAG_LAST = DIAG_W'(N_DIAG - 1);
    localparam logic [DRN_W-1:0]  DRN_LAST  = DRN_W'(DRAIN_CYCLES - 1);

    sched_state_t      state_q, state_d;
    logic [DIAG_W-1:0] diag_q, diag_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [DRN_W-1:0]  drain_q, drain_d;

    logic              write_cycle;
    logic [NUM_PU-1:0] diag_mask;

    pu_mask_gen #(
        .NUM_PU (NUM_PU),
        .DIAG_W (DIAG_W)
    ) u_mask (
        .diag (diag_q),
        .mask (diag_mask)
    );

    // A stalled write cycle is simply not a write cycle; it recurs once stall drops.
    assign write_cycle = (state_q == RUN) && (cyc_q == CYC_LAST) && !stall;

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            diag_q  <= '0;
            cyc_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            diag_q  <= diag_d;
            cyc_q   <= cyc_d;
            drain_q <= drain_d;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d = state_q;
        diag_d  = diag_q;
        cyc_d   = cyc_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    diag_d  = '0;
                    cyc_d   = '0;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (cyc_q == CYC_LAST) begin
                        cyc_d = '0;
                        if (diag_q == DIAG_LAST) begin
                            state_d = DRAIN;
                            drain_d = '0;
                        end else begin
                            diag_d = diag_q + 1'b1;
                        end
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == DRN_LAST) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                diag_d  = '0;
                cyc_d   = '0;
                drain_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from registered state (stall only gates the write strobes).
    always_comb begin
        ready           = (state_q == IDLE);
        busy            = (state_q != IDLE);
        done            = (state_q == DONE);
        choose_diagonal = (state_q == RUN) ? diag_q : '0;
        wr_en_max       = write_cycle;
        wr_en_pu        = write_cycle ? diag_mask : '0;
        write_ctl       = write_cycle ? (N_DIAG'(1) << diag_q) : '0;
    end

endmodule
